// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg -- shared constants, entry type and small helpers for the
// instruction queue sitting between fetch and the two decoders.
//
// Contents:
//   IQ_DEPTH / IQ_PTR_W / IQ_OCC_W  queue geometry (depth is a power of two)
//   IQ_NOP                          codeword presented on empty decode slots
//   ENABLE / DISABLE                single-bit control constants
//   iq_entry_t                      stored {ir, pc} pair
//   iq_enq_count()                  decode enq_valid into an entry count
//   iq_deq_clamp()                  legalise a requested dequeue count
package inst_queue_pkg;

  localparam int IQ_DEPTH = 8;
  localparam int IQ_PTR_W = $clog2(IQ_DEPTH);
  localparam int IQ_OCC_W = IQ_PTR_W + 1;

  localparam logic [31:0] IQ_NOP = 32'h0000_0013;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } iq_entry_t;

  // Only the two contiguous patterns are meaningful; slot1 without slot0
  // cannot come from fetch and is treated as no request.
  function automatic logic [1:0] iq_enq_count(input logic [1:0] valid);
    logic [1:0] cnt;
    case (valid)
      2'b01:   cnt = 2'd1;
      2'b11:   cnt = 2'd2;
      default: cnt = 2'd0;
    endcase
    return cnt;
  endfunction

  // A request of 3 cannot be served by two decoders, so it means 2; the
  // result is then limited to what is actually held.
  function automatic logic [1:0] iq_deq_clamp(input logic [1:0] req,
                                              input logic [IQ_OCC_W-1:0] occ);
    logic [1:0] cnt;
    cnt = (req == 2'd3) ? 2'd2 : req;
    if ({2'b00, cnt} > occ) begin
      cnt = occ[1:0];
    end
    return cnt;
  endfunction

endpackage

// File: rtl/inst_queue.sv
// inst_queue -- 8-entry circular instruction queue between fetch and the
// two decoders. Fetch pushes up to two codewords per cycle, decode pops up to
// two from the head. Outputs are show-ahead from head/head+1; empty slots
// present a NOP with PC 0.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset, highest priority
//   enq_valid  per-slot fetch valid (bit0 = older slot); 01 = one, 11 = two
//   enq_ir0/1  fetched codewords for slot0/slot1
//   enq_pc     PC of slot0 (slot1 is enq_pc+4)
//   enq_ready  queue has room for two entries (occupancy <= 6)
//   deq_valid  per-slot valid toward decoders (bit0 = older slot)
//   deq_ir0/1  codewords for decoder 0/1
//   deq_pc0/1  PCs matching deq_ir0/1
//   deq_count  entries consumed this cycle (3 is treated as 2)
//   flush      redirect: empties the queue, discarding this cycle's traffic
//   occupancy  current entry count 0..8
module inst_queue
  import inst_queue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  enq_valid,
  input  logic [31:0] enq_ir0,
  input  logic [31:0] enq_ir1,
  input  logic [31:0] enq_pc,
  output logic        enq_ready,
  output logic [1:0]  deq_valid,
  output logic [31:0] deq_ir0,
  output logic [31:0] deq_ir1,
  output logic [31:0] deq_pc0,
  output logic [31:0] deq_pc1,
  input  logic [1:0]  deq_count,
  input  logic        flush,
  output logic [3:0]  occupancy
);

  logic [IQ_PTR_W-1:0] head_q;
  logic [IQ_PTR_W-1:0] tail_q;
  logic [IQ_OCC_W-1:0] occ_q;

  logic [IQ_PTR_W-1:0] head_p1;
  logic [IQ_PTR_W-1:0] tail_p1;

  logic [1:0]          enq_cnt;
  logic [1:0]          deq_cnt;
  logic [IQ_OCC_W-1:0] occ_nxt;
  logic                wr_en;

  // Storage is deliberately not reset; occupancy masks stale contents.
  iq_entry_t mem [IQ_DEPTH];

  // Ready looks only at registered occupancy so fetch never sees a path
  // through the decoders' consume decision.
  assign enq_ready = (occ_q <= IQ_OCC_W'(IQ_DEPTH - 2));

  assign enq_cnt = enq_ready ? iq_enq_count(enq_valid) : 2'd0;
  assign deq_cnt = iq_deq_clamp(deq_count, occ_q);

  assign head_p1 = head_q + IQ_PTR_W'(1);
  assign tail_p1 = tail_q + IQ_PTR_W'(1);

  // Cannot leave 0..8: enqueue is gated at occupancy <= 6, dequeue is clamped.
  assign occ_nxt = occ_q + {2'b00, enq_cnt} - {2'b00, deq_cnt};

  assign wr_en = !rst && !flush && (enq_cnt != 2'd0);

  assign occupancy = occ_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else if (flush) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_q + {1'b0, deq_cnt};
      tail_q <= tail_q + {1'b0, enq_cnt};
      occ_q  <= occ_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[tail_q] <= '{ir: enq_ir0, pc: enq_pc};
      if (enq_cnt == 2'd2) begin
        mem[tail_p1] <= '{ir: enq_ir1, pc: enq_pc + 32'd4};
      end
    end
  end

  // Show-ahead read; no bypass from the write port, so a new entry appears
  // only once it is in the array.
  always_comb begin
    deq_valid = 2'b00;
    deq_ir0   = IQ_NOP;
    deq_ir1   = IQ_NOP;
    deq_pc0   = 32'd0;
    deq_pc1   = 32'd0;
    if (occ_q >= IQ_OCC_W'(1)) begin
      deq_valid[0] = ENABLE;
      deq_ir0      = mem[head_q].ir;
      deq_pc0      = mem[head_q].pc;
    end
    if (occ_q >= IQ_OCC_W'(2)) begin
      deq_valid[1] = ENABLE;
      deq_ir1      = mem[head_p1].ir;
      deq_pc1      = mem[head_p1].pc;
    end
  end

endmodule
